// File: rtl/sa_feed_ctrl_pkg.sv
// Shared types and constants for the systolic-array feed controller.
// SYS_ARRAY_LEN may be supplied by the build; it sets the default drain depth.
`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

package sa_feed_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } feed_state_e;

  localparam int SYS_ARRAY_LEN        = `SYS_ARRAY_LEN;
  // The skewed wavefront needs about twice the array edge to fully exit.
  localparam int DRAIN_CYCLES_DEFAULT = 2 * SYS_ARRAY_LEN;

endpackage

// File: rtl/sa_feed_ctrl_drain_timer.sv
// Drain timer: cleared while load is high, counts while count is high,
// and flags expire on the last counted cycle (CYCLES must be >= 1).
module sa_drain_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      cnt_reg <= '0;
    end else if (count) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expire = count && (cnt_reg == CW'(CYCLES - 1));

endmodule

// File: rtl/sa_feed_ctrl.sv
// Sequences one systolic-array tile pass: issues K fetches, qualifies returns, waits for drain.
// Optional SA_FEED_PERF_EN adds a stall_cycles counter port.
module sa_feed_ctrl
  import sa_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int CNT_W           = 16,
  parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEFAULT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  k_len,
  output logic              busy,
  output logic              done,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_gnt,
  input  logic              fetch_rvalid,
  output logic              data_valid,
  output logic              first_vec,
`ifdef SA_FEED_PERF_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              last_vec
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

  feed_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  klen_reg;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  recv_cnt_reg, recv_cnt_next;
  logic [CNT_W-1:0]  outstanding;
  logic              accept, in_stream, drain_expire;

  assign accept         = (state_reg == IDLE) && start;
  assign in_stream      = (state_reg == ISSUE) || (state_reg == WAIT);
  assign outstanding    = issue_cnt_reg - recv_cnt_reg;
  assign issue_cnt_next = issue_cnt_reg + CNT_W'(fetch_req && fetch_gnt);
  assign recv_cnt_next  = recv_cnt_reg + CNT_W'(data_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = (k_len == '0) ? DONE : ISSUE;
      // The last return can coincide with the last grant, so check it first.
      ISSUE: begin
        if (recv_cnt_next == klen_reg) begin
          state_next = DRAIN;
        end else if (issue_cnt_next == klen_reg) begin
          state_next = WAIT;
        end
      end
      WAIT:  if (recv_cnt_next == klen_reg) state_next = DRAIN;
      DRAIN: if (drain_expire) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    fetch_req  = (state_reg == ISSUE) && (issue_cnt_reg < klen_reg) && (outstanding < MAX_OUT_C);
    fetch_addr = (state_reg == ISSUE) ? base_reg + ADDR_W'(issue_cnt_reg) : '0;
    data_valid = in_stream && fetch_rvalid;
    first_vec  = data_valid && (recv_cnt_reg == '0);
    last_vec   = data_valid && (recv_cnt_reg == klen_reg - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_reg      <= '0;
      klen_reg      <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else if (accept) begin
      base_reg      <= base_addr;
      klen_reg      <= k_len;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else if (in_stream) begin
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  sa_drain_timer #(
    .CYCLES (DRAIN_CYCLES)
  ) u_drain_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_reg != DRAIN),
    .count  (state_reg == DRAIN),
    .expire (drain_expire)
  );

`ifdef SA_FEED_PERF_EN
  logic [31:0] stall_reg;

  // Bubbles in the return stream while the pass is still streaming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else if (accept) begin
      stall_reg <= '0;
    end else if (in_stream && !fetch_rvalid) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Self-checking bench for sa_feed_ctrl: directed passes plus random passes against a count-based model.
// Build with SA_FEED_PERF_EN to also check stall_cycles.
module tb_sa_feed_ctrl;

  localparam int DRAIN = 6;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] k_len = '0;
  logic        busy, done, fetch_req, data_valid, first_vec, last_vec;
  logic [15:0] fetch_addr;
  logic        fetch_gnt = 1'b0;
  logic        fetch_rvalid = 1'b0;
`ifdef SA_FEED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  sa_feed_ctrl #(
    .ADDR_W          (16),
    .CNT_W           (16),
    .DRAIN_CYCLES    (DRAIN),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
`ifdef SA_FEED_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .data_valid   (data_valid),
    .first_vec    (first_vec),
    .last_vec     (last_vec)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: a pass is described only by its counts of transfers and returns.
  bit pass_on = 0;
  int k_m = 0, base_m = 0, n_xfer = 0, n_ret = 0;
  int done_cyc = -1, start_cyc = 0, cyc = 0;
  longint stall_m = 0;
  bit just_reset = 0;

  // Fetcher model and stimulus knobs.
  int ret_q[$];
  int last_ret = 0;
  int gnt_pct = 100, blk_lo = 1000, blk_hi = 1000, lat_lo = 2, lat_hi = 2;
  int base_in = 0, klen_in = 0;
  bit drain_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic tick(input bit s, input bit r);
    bit g, rv, in_iw, e_req, e_dv;
    int rel, rt;
    @(negedge clk);
    rst_n = !r;
    start = s;
    if (s) begin
      base_addr = 16'(base_in);
      k_len     = 16'(klen_in);
    end else begin
      base_addr = 16'($urandom);
      k_len     = 16'($urandom);
    end
    rel = cyc - start_cyc;
    g = (int'($urandom_range(99)) < gnt_pct) && !(pass_on && rel >= blk_lo && rel <= blk_hi);
    fetch_gnt = g;
    rv = (ret_q.size() > 0) && (ret_q[0] <= cyc);
    fetch_rvalid = rv;
    #1;
    in_iw = pass_on && (k_m > 0) && (n_ret < k_m);
    e_req = in_iw && (n_xfer < k_m) && ((n_xfer - n_ret) < MAXO);
    e_dv  = in_iw && rv;
    check("busy", busy, pass_on);
    check("done", done, pass_on && (cyc == done_cyc));
    check("fetch_req", fetch_req, e_req);
    check("data_valid", data_valid, e_dv);
    check("first_vec", first_vec, e_dv && (n_ret == 0));
    check("last_vec", last_vec, e_dv && (n_ret == k_m - 1));
    if (e_req) check("fetch_addr", fetch_addr, (base_m + n_xfer) & 32'hFFFF);
    if (just_reset) check("addr_after_rst", fetch_addr, 0);
    if (pass_on) check("outstanding_le_max", ret_q.size() <= MAXO, 1);
`ifdef SA_FEED_PERF_EN
    check("stall_cycles", stall_cycles, 32'(stall_m));
`endif
    // Fetcher: returns in request order, at least one cycle after the grant.
    if (fetch_req && g) begin
      rt = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (rt <= last_ret) rt = last_ret + 1;
      last_ret = rt;
      ret_q.push_back(rt);
    end
    if (rv) void'(ret_q.pop_front());
    if (r) begin
      pass_on = 0; k_m = 0; n_xfer = 0; n_ret = 0; done_cyc = -1; stall_m = 0;
    end else begin
      if (e_req && g) n_xfer++;
      if (e_dv) begin
        n_ret++;
        if (n_ret == k_m) done_cyc = cyc + DRAIN + 1;
      end
      if (in_iw && !rv) stall_m++;
      if (pass_on && cyc == done_cyc) begin
        pass_on = 0;
      end else if (!pass_on && s) begin
        pass_on = 1; start_cyc = cyc; k_m = klen_in & 32'hFFFF; base_m = base_in & 32'hFFFF;
        n_xfer = 0; n_ret = 0; stall_m = 0;
        done_cyc = (k_m == 0) ? cyc + 1 : -1;
      end
    end
    just_reset = r;
    cyc++;
  endtask

  task automatic run_pass(input int b, input int k);
    base_in = b; klen_in = k;
    tick(1, 0);
    for (int n = 0; n < 400 && pass_on; n++) begin
      if (drain_start && n_ret == k_m && k_m > 0 && cyc < done_cyc) begin
        drain_start = 0;
        base_in = int'($urandom_range(16'hFFFF)); klen_in = 9;
        tick(1, 0);
      end else begin
        tick(0, 0);
      end
    end
    check("pass_complete", pass_on, 0);
    tick(0, 0);
    tick(0, 0);
  endtask

  initial begin
    // Reset state.
    tick(0, 1);
    tick(0, 1);
    tick(0, 0);

    // k=4 at 0x10, grant always, data two cycles after each grant.
    gnt_pct = 100; lat_lo = 2; lat_hi = 2;
    run_pass(16'h0010, 4);

    // Backpressure: grant low for cycles 2..5 after start, data six cycles late.
    blk_lo = 2; blk_hi = 5; lat_lo = 6; lat_hi = 6;
    run_pass(16'h0200, 6);
    blk_lo = 1000; blk_hi = 1000;

    // Empty pass.
    run_pass(16'h1234, 0);

    // Single vector at the top of the address space.
    lat_lo = 1; lat_hi = 3;
    run_pass(16'hFFFF, 1);

    // Start pulsed during drain must be ignored.
    drain_start = 1; lat_lo = 2; lat_hi = 2;
    run_pass(16'h0040, 5);

    // Reset mid-issue after two grants; late returns must stay invisible.
    lat_lo = 5; lat_hi = 5;
    base_in = 16'h0300; klen_in = 8;
    tick(1, 0);
    for (int n = 0; n < 50 && n_xfer < 2; n++) tick(0, 0);
    check("two_grants_before_rst", n_xfer, 2);
    tick(0, 1);
    for (int n = 0; n < 30 && ret_q.size() > 0; n++) tick(0, 0);
    check("late_returns_drained", ret_q.size(), 0);
    tick(0, 0);

    // Random passes with random grant pressure and return latency.
    for (int p = 0; p < 8; p++) begin
      gnt_pct = int'($urandom_range(100, 40));
      lat_lo  = 1;
      lat_hi  = int'($urandom_range(8, 1));
      run_pass(int'($urandom_range(16'hFFFF)), int'($urandom_range(12, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
